// File: rtl/div_unit_pkg.sv
// Shared encodings for the execute-stage divider: FSM states, ready/start
// levels and the zero word.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial register left, then
// trial-subtract the divisor from the upper DATA_W+1 bits.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  part_i,
    input  logic [DATA_W-1:0]  divisor_i,
    output logic [2*DATA_W:0]  part_o
);

    logic [2*DATA_W:0] shifted_s;
    logic [DATA_W:0]   upper_s;
    logic [DATA_W:0]   diff_s;
    logic              unused_msb_s;

    // The top bit is always clear between iterations (remainder < divisor).
    assign unused_msb_s = part_i[2*DATA_W];

    // Shift, trial-subtract and commit when the difference is non-negative.
    always_comb begin
        shifted_s = {part_i[2*DATA_W-1:0], 1'b0};
        upper_s   = shifted_s[2*DATA_W:DATA_W];
        diff_s    = upper_s - {1'b0, divisor_i};
        if (upper_s >= {1'b0, divisor_i}) begin
            part_o = {diff_s, shifted_s[DATA_W-1:1], 1'b1};
        end else begin
            part_o = shifted_s;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero_o output.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                div_zero_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W:0]   part_q, part_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                zero_path_q, zero_path_d;
    logic                div_zero_q, div_zero_d;
`endif

    logic [2*DATA_W:0]   step_s;
    logic [DATA_W-1:0]   dividend_abs_s;
    logic [DATA_W-1:0]   divisor_abs_s;
    logic [DATA_W-1:0]   quo_fix_s;
    logic [DATA_W-1:0]   rem_fix_s;

    div_step #(.DATA_W(DATA_W)) u_div_step (
        .part_i    (part_q),
        .divisor_i (divisor_q),
        .part_o    (step_s)
    );

    // Magnitudes at start and sign correction of the finished quotient/remainder.
    always_comb begin
        if (signed_div_i && opdata1_i[DATA_W-1]) begin
            dividend_abs_s = -opdata1_i;
        end else begin
            dividend_abs_s = opdata1_i;
        end
        if (signed_div_i && opdata2_i[DATA_W-1]) begin
            divisor_abs_s = -opdata2_i;
        end else begin
            divisor_abs_s = opdata2_i;
        end
        quo_fix_s = neg_quo_q ? -part_q[DATA_W-1:0] : part_q[DATA_W-1:0];
        rem_fix_s = neg_rem_q ? -part_q[2*DATA_W-1:DATA_W] : part_q[2*DATA_W-1:DATA_W];
    end

    // Next-state logic for the FREE/BYZERO/ON/END sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
        zero_path_d = zero_path_q;
        div_zero_d  = div_zero_q;
`endif
        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = {(2*DATA_W){1'b0}};
`ifdef DIV_ZERO_FLAG_EN
                zero_path_d = 1'b0;
                div_zero_d  = 1'b0;
`endif
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == {DATA_W{1'b0}}) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = {CNT_W{1'b0}};
                        part_d    = {{(DATA_W+1){1'b0}}, dividend_abs_s};
                        divisor_d = divisor_abs_s;
                        neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end else begin
                    state_d = DivFree;
                end
            end
            DivByZero: begin
                state_d   = DivEnd;
                part_d    = {(2*DATA_W+1){1'b0}};
                divisor_d = {DATA_W{1'b0}};
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                zero_path_d = 1'b1;
`endif
            end
            DivOn: begin
                if (annul_i) begin
                    state_d   = DivFree;
                    cnt_d     = {CNT_W{1'b0}};
                    part_d    = {(2*DATA_W+1){1'b0}};
                    divisor_d = {DATA_W{1'b0}};
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                end else begin
                    part_d = step_s;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DivEnd;
                    end else begin
                        state_d = DivOn;
                    end
                end
            end
            DivEnd: begin
                // Result is held until the execute stage drops its request.
                if (start_i == DivStop || annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = {(2*DATA_W){1'b0}};
`ifdef DIV_ZERO_FLAG_EN
                    zero_path_d = 1'b0;
                    div_zero_d  = 1'b0;
`endif
                end else begin
                    ready_d  = DivResultReady;
                    result_d = {rem_fix_s, quo_fix_s};
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_d = zero_path_q;
`endif
                end
            end
            default: begin
                state_d  = DivFree;
                ready_d  = DivResultNotReady;
                result_d = {(2*DATA_W){1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= {CNT_W{1'b0}};
            part_q    <= {(2*DATA_W+1){1'b0}};
            divisor_q <= {DATA_W{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {(2*DATA_W){1'b0}};
            ready_q   <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            zero_path_q <= 1'b0;
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
            zero_path_q <= zero_path_d;
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; honours DIV_ZERO_FLAG_EN when defined.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    int n_vec;
    int n_err;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o   (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges waited until ready is seen; -1 if it never arrives.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready === 1'b1) break;
        end
        if (ready !== 1'b1) cyc = -1;
    endtask

    // Raise start with operands; lat counts edges after the start edge.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res);
        int c;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        wait_ready(c);
        lat = (c < 0) ? -1 : c - 1;
        res = result;
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_vec++; if (result !== 64'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_hold_ready: got %b want 0", ready); end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd100, 32'd7, lat, res);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
        n_vec++; if (res !== 64'h00000002_0000000E) begin n_err++; $display("FAIL u100_7_result: got %h want 000000020000000e", res); end
`ifdef DIV_ZERO_FLAG_EN
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL u100_7_divzero: got %b want 0", div_zero); end
`endif
        drop_start();
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL u100_7_drop_ready: got %b want 0", ready); end
        n_vec++; if (result !== 64'h0) begin n_err++; $display("FAIL u100_7_drop_result: got %h want 0", result); end
    endtask

    task automatic test_signed();
        logic        sg [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] a  [5]  = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000064};
        logic [31:0] b  [5]  = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002, 32'h00000007};
        logic [63:0] exp[5]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'hFFFFFFFF_00000003,
                                 64'h00000001_7FFFFFFC, 64'h00000002_0000000E};
        int lat;
        logic [63:0] res;
        for (int i = 0; i < 5; i++) begin
            run_div(sg[i], a[i], b[i], lat, res);
            n_vec++; if (res !== exp[i]) begin n_err++; $display("FAIL signed_vec%0d_result: got %h want %h", i, res, exp[i]); end
            drop_start();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [63:0] res;
        run_div(1'b1, 32'h12345678, 32'h0, lat, res);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL divzero_latency: got %0d want 2", lat); end
        n_vec++; if (res !== 64'h0) begin n_err++; $display("FAIL divzero_result: got %h want 0", res); end
`ifdef DIV_ZERO_FLAG_EN
        n_vec++; if (div_zero !== 1'b1) begin n_err++; $display("FAIL divzero_flag: got %b want 1", div_zero); end
`endif
        drop_start();
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL divzero_drop_ready: got %b want 0", ready); end
`ifdef DIV_ZERO_FLAG_EN
        n_vec++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL divzero_flag_clear: got %b want 0", div_zero); end
`endif
    endtask

    task automatic test_boundary();
        int lat;
        logic [63:0] res;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
        n_vec++; if (res !== 64'h00000000_80000000) begin n_err++; $display("FAIL min_by_m1_result: got %h want 0000000080000000", res); end
        drop_start();
        run_div(1'b0, 32'hFFFFFFFF, 32'h1, lat, res);
        n_vec++; if (res !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL umax_by_1_result: got %h want 00000000ffffffff", res); end
        drop_start();
        run_div(1'b1, 32'h0, 32'h5, lat, res);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL zero_dividend_latency: got %0d want 33", lat); end
        n_vec++; if (res !== 64'h0) begin n_err++; $display("FAIL zero_dividend_result: got %h want 0", res); end
        drop_start();
    endtask

    task automatic test_operand_change();
        int c;
        signed_div = 1'b0;
        op1        = 32'd9;
        op2        = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        op1        = 32'd100;
        op2        = 32'd7;
        signed_div = 1'b1;
        start      = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        wait_ready(c);
        n_vec++; if (c !== 27) begin n_err++; $display("FAIL opchange_latency: got %0d want 27", c); end
        n_vec++; if (result !== 64'h00000000_00000003) begin n_err++; $display("FAIL opchange_result: got %h want 0000000000000003", result); end
        drop_start();
    endtask

    task automatic test_annul();
        int seen;
        int lat;
        logic [63:0] res;
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        annul = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL annul_no_ready: got %0d ready cycles want 0", seen); end
        run_div(1'b0, 32'd9, 32'd3, lat, res);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL annul_next_latency: got %0d want 33", lat); end
        n_vec++; if (res !== 64'h00000000_00000003) begin n_err++; $display("FAIL annul_next_result: got %h want 0000000000000003", res); end
        drop_start();
    endtask

    task automatic test_async_reset();
        int lat;
        logic [63:0] res;
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_on_ready: got %b want 0", ready); end
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd50, 32'd5, lat, res);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL rst_next_latency: got %0d want 33", lat); end
        n_vec++; if (res !== 64'h00000000_0000000A) begin n_err++; $display("FAIL rst_next_result: got %h want 000000000000000a", res); end
        // Reset while the result is being held must clear it without a clock edge.
        #2 rst = 1'b0;
        #1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_in_end_ready: got %b want 0", ready); end
        n_vec++; if (result !== 64'h0) begin n_err++; $display("FAIL rst_in_end_result: got %h want 0", result); end
        start = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd9, 32'd3, lat, res);
        n_vec++; if (res !== 64'h00000000_00000003) begin n_err++; $display("FAIL b2b_first_result: got %h want 0000000000000003", res); end
        drop_start();
        run_div(1'b1, 32'hFFFFFFCE, 32'd5, lat, res);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        n_vec++; if (res !== 64'h00000000_FFFFFFF6) begin n_err++; $display("FAIL b2b_second_result: got %h want 00000000fffffff6", res); end
        drop_start();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = 32'h0;
        op2        = 32'h0;
        start      = 1'b0;
        annul      = 1'b0;
        #2;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_boundary();
        test_operand_change();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
